// File: rtl/key_conditioner.sv
// ---------------------------------------------------------------------------
// key_conditioner
//   Per-key front end for the board push-buttons. Each raw active-low key is
//   passed through a 2-FF synchroniser and then a debounce/hold FSM that
//   produces a clean level plus single-cycle press, release, long-hold and
//   auto-repeat pulses. All channels are identical and independent.
//
// Ports
//   clk          system clock (50 MHz)
//   reset        synchronous reset, active-low
//   key_raw_n    raw asynchronous keys, 0 = pressed
//   key_n        debounced level, 0 = pressed
//   key_press    1-cycle pulse on accepted press
//   key_release  1-cycle pulse on accepted release
//   key_long     1-cycle pulse when the hold reaches LONG_CYCLES
//   key_repeat   1-cycle pulse every REPEAT_CYCLES after key_long while held
//   any_held     high while any debounced key is pressed
// ---------------------------------------------------------------------------
module key_conditioner #(
   parameter int NUM_KEYS        = 4,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int LONG_CYCLES     = 150_000_000,
   parameter int REPEAT_CYCLES   = 12_500_000,
   parameter int CNT_W           = 28
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] key_raw_n,
   output logic [NUM_KEYS-1:0] key_n,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_long,
   output logic [NUM_KEYS-1:0] key_repeat,
   output logic                any_held
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      DB_PRESS   = 3'd1,
      HELD       = 3'd2,
      LONG_HELD  = 3'd3,
      DB_RELEASE = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [NUM_KEYS-1:0] sync_a;
   logic [NUM_KEYS-1:0] sync_b;
   logic [NUM_KEYS-1:0] key_n_nxt;

   // Two-stage synchroniser; reset to the released level.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_a <= '1;
         sync_b <= '1;
      end else begin
         sync_a <= key_raw_n;
         sync_b <= sync_a;
      end
   end

   // any_held follows the next-state level so it lines up with key_n.
   always_ff @(posedge clk) begin
      if (!reset) any_held <= 1'b0;
      else        any_held <= |(~key_n_nxt);
   end

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      state_t           state, state_nxt;
      logic             origin_long, origin_long_nxt;
      logic [CNT_W-1:0] db_cnt, db_nxt;
      logic [CNT_W-1:0] hold_cnt, hold_nxt;
      logic [CNT_W-1:0] rep_cnt, rep_nxt;
      logic             key_n_r, level_nxt;
      logic             press_r, press_nxt;
      logic             release_r, release_nxt;
      logic             long_r, long_nxt;
      logic             repeat_r, repeat_nxt;
      logic             sync;

      assign sync         = sync_b[i];
      assign key_n_nxt[i] = level_nxt;
      assign key_n[i]       = key_n_r;
      assign key_press[i]   = press_r;
      assign key_release[i] = release_r;
      assign key_long[i]    = long_r;
      assign key_repeat[i]  = repeat_r;

      // State and registered outputs.
      always_ff @(posedge clk) begin
         if (!reset) begin
            state       <= IDLE;
            origin_long <= 1'b0;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            rep_cnt     <= '0;
            key_n_r     <= 1'b1;
            press_r     <= 1'b0;
            release_r   <= 1'b0;
            long_r      <= 1'b0;
            repeat_r    <= 1'b0;
         end else begin
            state       <= state_nxt;
            origin_long <= origin_long_nxt;
            db_cnt      <= db_nxt;
            hold_cnt    <= hold_nxt;
            rep_cnt     <= rep_nxt;
            key_n_r     <= level_nxt;
            press_r     <= press_nxt;
            release_r   <= release_nxt;
            long_r      <= long_nxt;
            repeat_r    <= repeat_nxt;
         end
      end

      // Next-state and counter update.
      // A counter sitting on its terminal value is not advanced when a
      // release debounce starts, so the pending event fires on the first
      // held cycle after a rejected bounce instead of being skipped.
      always_comb begin
         state_nxt       = state;
         origin_long_nxt = origin_long;
         db_nxt          = db_cnt;
         hold_nxt        = hold_cnt;
         rep_nxt         = rep_cnt;
         case (state)
            IDLE: begin
               if (!sync) begin
                  state_nxt = DB_PRESS;
                  db_nxt    = CNT_ONE;
               end
            end
            DB_PRESS: begin
               if (sync) begin
                  state_nxt = IDLE;
                  db_nxt    = '0;
               end else if (db_cnt == DB_LAST) begin
                  state_nxt = HELD;
                  db_nxt    = '0;
                  hold_nxt  = '0;
               end else begin
                  db_nxt = db_cnt + CNT_ONE;
               end
            end
            HELD: begin
               if (sync) begin
                  state_nxt       = DB_RELEASE;
                  origin_long_nxt = 1'b0;
                  db_nxt          = CNT_ONE;
                  if (hold_cnt != LONG_LAST) hold_nxt = hold_cnt + CNT_ONE;
               end else if (hold_cnt == LONG_LAST) begin
                  state_nxt = LONG_HELD;
                  rep_nxt   = '0;
               end else begin
                  hold_nxt = hold_cnt + CNT_ONE;
               end
            end
            LONG_HELD: begin
               if (sync) begin
                  state_nxt       = DB_RELEASE;
                  origin_long_nxt = 1'b1;
                  db_nxt          = CNT_ONE;
                  if (rep_cnt != REP_LAST) rep_nxt = rep_cnt + CNT_ONE;
               end else if (rep_cnt == REP_LAST) begin
                  rep_nxt = '0;
               end else begin
                  rep_nxt = rep_cnt + CNT_ONE;
               end
            end
            DB_RELEASE: begin
               // hold_cnt / rep_cnt stay frozen while the release is judged.
               if (!sync) begin
                  state_nxt = origin_long ? LONG_HELD : HELD;
                  db_nxt    = '0;
               end else if (db_cnt == DB_LAST) begin
                  state_nxt       = IDLE;
                  origin_long_nxt = 1'b0;
                  db_nxt          = '0;
                  hold_nxt        = '0;
                  rep_nxt         = '0;
               end else begin
                  db_nxt = db_cnt + CNT_ONE;
               end
            end
            default: begin
               state_nxt = IDLE;
               db_nxt    = '0;
               hold_nxt  = '0;
               rep_nxt   = '0;
            end
         endcase
      end

      // Output decode; values are registered on the same edge as the state.
      always_comb begin
         level_nxt   = key_n_r;
         press_nxt   = 1'b0;
         release_nxt = 1'b0;
         long_nxt    = 1'b0;
         repeat_nxt  = 1'b0;
         case (state)
            DB_PRESS: begin
               if (!sync && db_cnt == DB_LAST) begin
                  press_nxt = 1'b1;
                  level_nxt = 1'b0;
               end
            end
            HELD: begin
               if (!sync && hold_cnt == LONG_LAST) long_nxt = 1'b1;
            end
            LONG_HELD: begin
               if (!sync && rep_cnt == REP_LAST) repeat_nxt = 1'b1;
            end
            DB_RELEASE: begin
               if (sync && db_cnt == DB_LAST) begin
                  release_nxt = 1'b1;
                  level_nxt   = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_key_conditioner.sv
// ---------------------------------------------------------------------------
// tb_key_conditioner
//   Self-checking bench for key_conditioner with short timing parameters.
//   A behavioural model tracks, per key, the debounced level, the length of
//   the current run of disagreeing synchronised samples, and a hold timeline
//   (active ticks since press, with the tick at which the next long/repeat
//   event is due). Directed scenarios check the timing rules with constants.
// ---------------------------------------------------------------------------
module tb_key_conditioner;

   localparam int NK   = 2;
   localparam int DEB  = 4;
   localparam int LONG = 20;
   localparam int REP  = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic [NK-1:0] key_raw_n;
   logic [NK-1:0] key_n, key_press, key_release, key_long, key_repeat;
   logic          any_held;

   int checks = 0;
   int passes = 0;

   key_conditioner #(
      .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG),
      .REPEAT_CYCLES(REP), .CNT_W(28)
   ) dut (
      .clk(clk), .reset(reset), .key_raw_n(key_raw_n), .key_n(key_n),
      .key_press(key_press), .key_release(key_release), .key_long(key_long),
      .key_repeat(key_repeat), .any_held(any_held)
   );

   always #10 clk = ~clk;

   // ---------------- reference model ----------------
   logic [NK-1:0] m_s1, m_s2, m_level, m_press, m_rel, m_long, m_rep;
   logic          m_any;
   int            m_run[NK];
   int            m_ticks[NK];
   int            m_due[NK];

   always @(posedge clk) begin
      if (!reset) begin
         m_s1 = '1; m_s2 = '1; m_level = '1;
         m_press = '0; m_rel = '0; m_long = '0; m_rep = '0; m_any = 1'b0;
         for (int k = 0; k < NK; k++) begin
            m_run[k] = 0; m_ticks[k] = 0; m_due[k] = 0;
         end
      end else begin
         for (int k = 0; k < NK; k++) begin
            m_press[k] = 1'b0; m_rel[k] = 1'b0; m_long[k] = 1'b0; m_rep[k] = 1'b0;
            if (m_level[k]) begin
               // released: need DEB+1 consecutive low samples
               if (!m_s2[k]) m_run[k]++; else m_run[k] = 0;
               if (m_run[k] == DEB + 1) begin
                  m_level[k] = 1'b0; m_press[k] = 1'b1; m_run[k] = 0;
                  m_ticks[k] = 0; m_due[k] = LONG;
               end
            end else if (m_run[k] > 0) begin
               // release being judged: hold timeline frozen
               if (m_s2[k]) m_run[k]++; else m_run[k] = 0;
               if (m_run[k] == DEB + 1) begin
                  m_level[k] = 1'b1; m_rel[k] = 1'b1; m_run[k] = 0;
               end
            end else if (m_s2[k]) begin
               // release candidate starts; a due event waits for the return
               m_run[k] = 1;
               if (m_ticks[k] + 1 != m_due[k]) m_ticks[k]++;
            end else begin
               m_ticks[k]++;
               if (m_ticks[k] == m_due[k]) begin
                  if (m_due[k] == LONG) m_long[k] = 1'b1; else m_rep[k] = 1'b1;
                  m_due[k] += REP;
               end
            end
         end
         m_s2  = m_s1;
         m_s1  = key_raw_n;
         m_any = |(~m_level);
      end
   end

   logic [5*NK:0] obs, expv;
   always_comb obs  = {key_n, key_press, key_release, key_long, key_repeat, any_held};
   always_comb expv = {m_level, m_press, m_rel, m_long, m_rep, m_any};

   // Apply inputs just after a negedge and advance to the next negedge.
   task automatic drive(input logic [NK-1:0] raw, input logic rs);
      key_raw_n = raw;
      reset     = rs;
      @(negedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int ev;
      for (int c = 0; c < 3; c++) drive(2'b11, 1'b0);
      checks++;
      if (obs !== {2'b11, 8'b0, 1'b0})
         $display("FAIL reset_state got %b want %b", obs, {2'b11, 8'b0, 1'b0});
      else passes++;
      ev = 0;
      for (int c = 0; c < 50; c++) begin
         drive(2'b11, 1'b1);
         checks++;
         if (obs !== expv) $display("FAIL model_idle got %b want %b", obs, expv);
         else passes++;
         if ((key_press | key_release | key_long | key_repeat) != '0) ev++;
      end
      checks++;
      if (ev != 0 || key_n !== 2'b11 || any_held !== 1'b0)
         $display("FAIL idle_quiet events %0d key_n %b want 0 events, 11", ev, key_n);
      else passes++;
   endtask

   task automatic test_press_long();
      int lat, long_at, rel_lat, late_rep, got;
      int rep_q[$];
      lat = -1;
      for (int t = 0; t < 20 && lat < 0; t++) begin
         drive(2'b10, 1'b1);
         checks++;
         if (obs !== expv) $display("FAIL model_press got %b want %b", obs, expv);
         else passes++;
         if (key_press[0] === 1'b1) lat = t;
      end
      checks++;
      if (lat != DEB + 2) $display("FAIL press_latency got %0d want %0d", lat, DEB + 2);
      else passes++;
      checks++;
      if ({key_n, any_held, key_press[1]} !== 4'b1010)
         $display("FAIL press_level got %b want 1010", {key_n, any_held, key_press[1]});
      else passes++;
      long_at = -1;
      for (int t = 1; t <= 35; t++) begin
         drive(2'b10, 1'b1);
         checks++;
         if (obs !== expv) $display("FAIL model_hold got %b want %b", obs, expv);
         else passes++;
         if (t == 1) begin
            checks++;
            if (key_press[0] !== 1'b0 || key_n[0] !== 1'b0)
               $display("FAIL press_width press %b key_n %b want 0 0", key_press[0], key_n[0]);
            else passes++;
         end
         if (key_long[0] === 1'b1 && long_at < 0) long_at = t;
         if (key_repeat[0] === 1'b1) rep_q.push_back(t);
      end
      checks++;
      if (long_at != LONG) $display("FAIL long_time got %0d want %0d", long_at, LONG);
      else passes++;
      checks++;
      if (rep_q.size() != 3) $display("FAIL repeat_count got %0d want 3", rep_q.size());
      else passes++;
      for (int j = 0; j < 3; j++) begin
         got = (j < rep_q.size()) ? rep_q[j] : -1;
         checks++;
         if (got != LONG + (j + 1) * REP)
            $display("FAIL repeat_time%0d got %0d want %0d", j, got, LONG + (j + 1) * REP);
         else passes++;
      end
      rel_lat = -1; late_rep = 0;
      for (int t = 0; t < 20 && rel_lat < 0; t++) begin
         drive(2'b11, 1'b1);
         checks++;
         if (obs !== expv) $display("FAIL model_release got %b want %b", obs, expv);
         else passes++;
         if (key_repeat[0] === 1'b1) late_rep++;
         if (key_release[0] === 1'b1) rel_lat = t;
      end
      checks++;
      if (rel_lat != DEB + 2) $display("FAIL release_latency got %0d want %0d", rel_lat, DEB + 2);
      else passes++;
      checks++;
      if (late_rep != 0) $display("FAIL trailing_repeat got %0d want 0", late_rep);
      else passes++;
      drive(2'b11, 1'b1);
      checks++;
      if ({key_n, any_held, key_release[0]} !== 4'b1100)
         $display("FAIL release_level got %b want 1100", {key_n, any_held, key_release[0]});
      else passes++;
   endtask

   task automatic test_glitch();
      int presses, rels;
      for (int len = DEB - 1; len <= DEB; len++) begin
         presses = 0;
         for (int t = 0; t < len + 12; t++) begin
            drive((t < len) ? 2'b10 : 2'b11, 1'b1);
            checks++;
            if (obs !== expv) $display("FAIL model_glitch got %b want %b", obs, expv);
            else passes++;
            if (key_press[0] === 1'b1) presses++;
         end
         checks++;
         if (presses != 0 || key_n !== 2'b11)
            $display("FAIL glitch_len%0d presses %0d key_n %b want 0, 11", len, presses, key_n);
         else passes++;
      end
      presses = 0; rels = 0;
      for (int t = 0; t < DEB + 1 + 12; t++) begin
         drive((t < DEB + 1) ? 2'b10 : 2'b11, 1'b1);
         checks++;
         if (obs !== expv) $display("FAIL model_threshold got %b want %b", obs, expv);
         else passes++;
         if (key_press[0] === 1'b1) presses++;
         if (key_release[0] === 1'b1) rels++;
      end
      checks++;
      if (presses != 1 || rels != 1)
         $display("FAIL threshold_pulse presses %0d releases %0d want 1 1", presses, rels);
      else passes++;
   endtask

   task automatic test_held_bounce();
      int lat, long_at, bad;
      lat = -1;
      for (int t = 0; t < 20 && lat < 0; t++) begin
         drive(2'b10, 1'b1);
         checks++;
         if (obs !== expv) $display("FAIL model_bounce_press got %b want %b", obs, expv);
         else passes++;
         if (key_press[0] === 1'b1) lat = t;
      end
      checks++;
      if (lat != DEB + 2) $display("FAIL bounce_press_latency got %0d want %0d", lat, DEB + 2);
      else passes++;
      long_at = -1; bad = 0;
      for (int t = 1; t <= LONG + 10 && long_at < 0; t++) begin
         drive((t == 5 || t == 6) ? 2'b11 : 2'b10, 1'b1);
         checks++;
         if (obs !== expv) $display("FAIL model_bounce got %b want %b", obs, expv);
         else passes++;
         if (key_release[0] === 1'b1 || key_n[0] !== 1'b0) bad++;
         if (key_long[0] === 1'b1) long_at = t;
      end
      checks++;
      if (long_at != LONG + 2) $display("FAIL bounce_long_time got %0d want %0d", long_at, LONG + 2);
      else passes++;
      checks++;
      if (bad != 0) $display("FAIL bounce_release got %0d want 0", bad);
      else passes++;
      for (int t = 0; t < 12; t++) begin
         drive(2'b11, 1'b1);
         checks++;
         if (obs !== expv) $display("FAIL model_bounce_rel got %b want %b", obs, expv);
         else passes++;
      end
   endtask

   task automatic test_reset_long();
      int lat, rels, long_at;
      long_at = -1;
      for (int t = 0; t < DEB + 2 + LONG + 10 && long_at < 0; t++) begin
         drive(2'b10, 1'b1);
         checks++;
         if (obs !== expv) $display("FAIL model_to_long got %b want %b", obs, expv);
         else passes++;
         if (key_long[0] === 1'b1) long_at = t;
      end
      checks++;
      if (long_at != DEB + 2 + LONG) $display("FAIL reach_long got %0d want %0d", long_at, DEB + 2 + LONG);
      else passes++;
      for (int t = 0; t < 3; t++) drive(2'b10, 1'b1);
      drive(2'b10, 1'b0);
      checks++;
      if ({key_n, key_release, any_held} !== 5'b11000)
         $display("FAIL reset_mid_hold got %b want 11000", {key_n, key_release, any_held});
      else passes++;
      lat = -1; rels = 0;
      for (int t = 0; t < 20 && lat < 0; t++) begin
         drive(2'b10, 1'b1);
         checks++;
         if (obs !== expv) $display("FAIL model_after_reset got %b want %b", obs, expv);
         else passes++;
         if (key_release[0] === 1'b1) rels++;
         if (key_press[0] === 1'b1) lat = t;
      end
      checks++;
      if (lat != DEB + 2) $display("FAIL repress_latency got %0d want %0d", lat, DEB + 2);
      else passes++;
      checks++;
      if (rels != 0) $display("FAIL reset_release got %0d want 0", rels);
      else passes++;
      for (int t = 0; t < 12; t++) drive(2'b11, 1'b1);
   endtask

   task automatic test_random();
      int            rem[NK];
      logic [NK-1:0] lvl;
      logic          rs;
      lvl = '1;
      for (int k = 0; k < NK; k++) rem[k] = 0;
      for (int c = 0; c < 4000; c++) begin
         for (int k = 0; k < NK; k++) begin
            if (rem[k] == 0) begin
               lvl[k] = ~lvl[k];
               case ($urandom_range(0, 3))
                  0:       rem[k] = $urandom_range(1, 3);
                  1:       rem[k] = $urandom_range(3, 7);
                  2:       rem[k] = $urandom_range(8, 24);
                  default: rem[k] = $urandom_range(25, 70);
               endcase
            end
            rem[k]--;
         end
         rs = ($urandom_range(0, 399) != 0);
         drive(lvl, rs);
         checks++;
         if (obs !== expv) $display("FAIL model_random got %b want %b", obs, expv);
         else passes++;
      end
   endtask

   initial begin
      reset     = 1'b0;
      key_raw_n = '1;
      @(negedge clk);
      test_reset();
      test_press_long();
      test_glitch();
      test_held_bounce();
      test_reset_long();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
